// File: rtl/alu_pkg.sv
// Shared constants for the shared-ALU arbiter: widths, opcodes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int RES_W  = DATA_W + 1;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_INC = 3'b110;
    localparam logic [OP_W-1:0] OP_DEC = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU; bit 8 of the result carries the carry/borrow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu_8bit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   sel_i,
    output logic [RES_W-1:0]  result_o
);

    // Decode the opcode; the 3-bit space is fully used so no illegal codes exist.
    always_comb begin
        result_o = '0;
        case (sel_i)
            OP_AND:  result_o = {1'b0, a_i & b_i};
            OP_OR:   result_o = {1'b0, a_i | b_i};
            OP_ADD:  result_o = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  result_o = {1'b0, a_i} - {1'b0, b_i};
            OP_XOR:  result_o = {1'b0, a_i ^ b_i};
            OP_NOT:  result_o = {1'b0, ~a_i};
            OP_INC:  result_o = {1'b0, a_i} + 9'd1;
            OP_DEC:  result_o = {1'b0, a_i} - 9'd1;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu_8bit between two valid/ready requesters.
// Latency: accept edge T, response valid from T+2; at least 3 cycles per transaction.
// Backpressure: holds the response (and refuses new requests) until the winner's rsp_ready.
module alu_share_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_sel,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [RES_W-1:0]  rsp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_sel,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [RES_W-1:0]  rsp1_result,
    output logic              busy,
    output logic              grant_id
);

    state_e              state_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [OP_W-1:0]     sel_q;
    logic                grant_q;
    logic                last_grant_q;
    logic [RES_W-1:0]    res_q;
    logic                rsp0_valid_q;
    logic                rsp1_valid_q;
    logic                busy_q;
    logic [RES_W-1:0]    alu_res;

    logic                winner;
    logic                accept;
    logic                rsp_done;

    // Pick the requester: the lone valid one, or the port that did not win last time.
    always_comb begin
        winner   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        // Gating with rst_n keeps both readies low while reset is held.
        accept   = rst_n && (state_q == S_IDLE) && (req0_valid || req1_valid);
        rsp_done = grant_q ? (rsp1_valid_q && rsp1_ready) : (rsp0_valid_q && rsp0_ready);
    end

    // The accept pulse is combinational so the requester sees it in the cycle it is taken.
    assign req0_ready  = accept && !winner;
    assign req1_ready  = accept &&  winner;

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_valid_q ? res_q : '0;
    assign rsp1_result = rsp1_valid_q ? res_q : '0;
    assign busy        = busy_q;
    assign grant_id    = grant_q;

    alu_8bit u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sel_i    (sel_q),
        .result_o (alu_res)
    );

    // Transaction FSM: capture operands on accept, execute, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= S_EXEC;
                        grant_q <= winner;
                        busy_q  <= 1'b1;
                        a_q     <= winner ? req1_a   : req0_a;
                        b_q     <= winner ? req1_b   : req0_b;
                        sel_q   <= winner ? req1_sel : req0_sel;
                    end
                end
                S_EXEC: begin
                    state_q <= S_RESP;
                    res_q   <= alu_res;
                    if (grant_q) begin
                        rsp1_valid_q <= 1'b1;
                    end else begin
                        rsp0_valid_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_done) begin
                        state_q      <= S_IDLE;
                        last_grant_q <= grant_q;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases then random rounds.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low for a chosen number of cycles.
module tb_alu_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [7:0] req0_a, req0_b;
    logic [2:0] req0_sel;
    logic [8:0] rsp0_result;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [7:0] req1_a, req1_b;
    logic [2:0] req1_sel;
    logic [8:0] rsp1_result;
    logic       busy, grant_id;

    int checks = 0;
    int errors = 0;

    // Reference state: pending requests per port and the last port served.
    bit         pend [2];
    logic [7:0] ca [2], cb [2], na [2], nb [2];
    logic [2:0] cs [2], ns [2];
    int         m_last;
    int         last_win;
    logic [8:0] last_res;

    alu_share_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_sel    (req0_sel),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_sel    (req1_sel),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Arithmetic reference for the 8 opcodes, result taken modulo 512.
    function automatic logic [8:0] alu_ref(input int a, input int b, input int s);
        int r;
        case (s)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a + b;
            3:       r = a - b;
            4:       r = a ^ b;
            5:       r = 255 - a;
            6:       r = a + 1;
            default: r = a - 1;
        endcase
        return 9'(r);
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        req0_valid = pend[0];
        req0_a     = ca[0];
        req0_b     = cb[0];
        req0_sel   = cs[0];
        req1_valid = pend[1];
        req1_a     = ca[1];
        req1_b     = cb[1];
        req1_sel   = cs[1];
    endtask

    // One complete transaction; new requests come from na/nb/ns for ports that want one.
    task automatic run_round(input bit w0, input bit w1, input int bp);
        int         exp_win;
        int         k;
        logic [8:0] exp_res;
        if (w0 && !pend[0]) begin pend[0] = 1; ca[0] = na[0]; cb[0] = nb[0]; cs[0] = ns[0]; end
        if (w1 && !pend[1]) begin pend[1] = 1; ca[1] = na[1]; cb[1] = nb[1]; cs[1] = ns[1]; end
        drive();
        if (!pend[0] && !pend[1]) return;
        exp_win = (pend[0] && pend[1]) ? 1 - m_last : (pend[1] ? 1 : 0);
        exp_res = alu_ref(int'(ca[exp_win]), int'(cb[exp_win]), int'(cs[exp_win]));
        #1;
        k = 0;
        while (!(req0_ready || req1_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!(req0_ready || req1_ready)) begin
            check("accept_timeout", 16'd0, 16'd1);
            return;
        end
        check("req0_ready", 16'(req0_ready), 16'(exp_win == 0));
        check("req1_ready", 16'(req1_ready), 16'(exp_win == 1));
        @(posedge clk);
        #1;
        pend[exp_win] = 0;
        drive();
        @(negedge clk);
        check("exec_busy", 16'(busy), 16'd1);
        check("exec_grant", 16'(grant_id), 16'(exp_win));
        check("exec_rsp_v", 16'({rsp1_valid, rsp0_valid}), 16'd0);
        check("exec_ready", 16'({req1_ready, req0_ready}), 16'd0);
        for (int c = 0; c <= bp; c++) begin
            @(negedge clk);
            check("rsp_valid", 16'({rsp1_valid, rsp0_valid}), 16'(exp_win == 1 ? 2 : 1));
            check("rsp_result", exp_win == 1 ? 16'(rsp1_result) : 16'(rsp0_result), 16'(exp_res));
            check("resp_busy", 16'(busy), 16'd1);
            check("resp_ready", 16'({req1_ready, req0_ready}), 16'd0);
        end
        if (exp_win == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);
        check("rsp_released", 16'({rsp1_valid, rsp0_valid}), 16'd0);
        check("idle_busy", 16'(busy), 16'd0);
        m_last   = exp_win;
        last_win = exp_win;
        last_res = exp_res;
    endtask

    initial begin
        logic [8:0] sweep_tab [8];
        int         prev;
        sweep_tab[0] = 9'h088; sweep_tab[1] = 9'h0EE; sweep_tab[2] = 9'h176; sweep_tab[3] = 9'h1DE;
        sweep_tab[4] = 9'h066; sweep_tab[5] = 9'h055; sweep_tab[6] = 9'h0AB; sweep_tab[7] = 9'h0A9;

        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; ca[p] = '0; cb[p] = '0; cs[p] = '0;
            na[p] = '0; nb[p] = '0; ns[p] = '0;
        end
        drive();
        m_last   = 1;
        last_win = -1;
        last_res = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 16'({req1_ready, req0_ready}), 16'd0);
        check("rst_rsp_v", 16'({rsp1_valid, rsp0_valid}), 16'd0);
        check("rst_results", 16'(rsp0_result | rsp1_result), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_grant", 16'(grant_id), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Port 0 alone, AND.
        na[0] = 8'hAA; nb[0] = 8'hCC; ns[0] = 3'b000;
        run_round(1, 0, 0);
        check("t1_result", 16'(last_res), 16'h088);
        check("t1_winner", 16'(last_win), 16'd0);

        // Port 1 alone, ADD with carry out.
        na[1] = 8'hAA; nb[1] = 8'hCC; ns[1] = 3'b010;
        run_round(0, 1, 0);
        check("t2_result", 16'(last_res), 16'h176);
        check("t2_winner", 16'(last_win), 16'd1);

        // Both ports continuously requesting: strict alternation.
        prev = last_win;
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 2; p++) begin
                na[p] = 8'($urandom); nb[p] = 8'($urandom); ns[p] = 3'($urandom);
            end
            run_round(1, 1, 0);
            check("t3_alternate", 16'(last_win != prev), 16'd1);
            prev = last_win;
        end

        // Backpressure on port 0 for 5 cycles while port 1 waits.
        na[0] = 8'h5A; nb[0] = 8'h33; ns[0] = 3'b011;
        run_round(1, 1, 5);
        check("t4_winner", 16'(last_win), 16'd0);
        run_round(0, 0, 0);
        check("t4_drain", 16'(last_win), 16'd1);

        // Reset while in EXEC, with both requesters still asserting valid.
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1; ca[p] = 8'h11; cb[p] = 8'h22; cs[p] = 3'b010;
        end
        drive();
        @(posedge clk);
        #1;
        check("t5_in_exec", 16'(busy), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 16'(busy), 16'd0);
        check("t5_rst_grant", 16'(grant_id), 16'd0);
        check("t5_rst_ready", 16'({req1_ready, req0_ready}), 16'd0);
        check("t5_rst_rsp", 16'({rsp1_valid, rsp0_valid}), 16'd0);
        check("t5_rst_res", 16'(rsp0_result | rsp1_result), 16'd0);
        pend[0] = 0;
        pend[1] = 0;
        drive();
        m_last = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        na[0] = 8'h01; nb[0] = 8'h02; ns[0] = 3'b001;
        na[1] = 8'h03; nb[1] = 8'h04; ns[1] = 3'b100;
        run_round(1, 1, 0);
        check("t5_first_winner", 16'(last_win), 16'd0);
        run_round(0, 0, 0);

        // Opcode sweep on port 0 against a fixed table.
        for (int s = 0; s < 8; s++) begin
            na[0] = 8'hAA; nb[0] = 8'hCC; ns[0] = 3'(s);
            run_round(1, 0, 0);
            check("t6_sweep", 16'(last_res), 16'(sweep_tab[s]));
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                na[p] = 8'($urandom); nb[p] = 8'($urandom); ns[p] = 3'($urandom);
            end
            run_round(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
        run_round(0, 0, 0);
        run_round(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
